pc_next_unit: RTL and testbench

Program-counter register and next-address selector for the MIPS16 fetch stage. It replaces the stand-alone two-way jump-register mux with one clocked unit. The unit arbitrates between sequential, branch, jump, jump-register and return sources, and holds a small return-address stack (RAS) for call/return. Its output `pc` drives instruction-memory addressing directly. A registered `redirect` flag tells the pipeline to flush.

---
 rtl/pc_next_unit.sv | 144 ++++++++++++++
 tb/tb_pc_next_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// Program counter and next-address selector for the MIPS16 fetch stage.
// Arbitrates jr / return / jump / branch / sequential sources and keeps a circular return-address stack.
module pc_next_unit #(
    parameter int                ADDR_W    = 13,
    parameter int                DATA_W    = 16,
    parameter int                RAS_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = {ADDR_W{1'b0}}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic              jr_en,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              br_en,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_offset,
    input  logic              link_en,
    input  logic              ret_en,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus1,
    output logic              redirect,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_overflow
);

    localparam int PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int CNT_W = $clog2(RAS_DEPTH + 1);

    logic [ADDR_W-1:0] pc_r;
    logic              redirect_r;
    logic              overflow_r;
    logic [ADDR_W-1:0] ras_mem_r [RAS_DEPTH];
    logic [PTR_W-1:0]  top_r;
    logic [CNT_W-1:0]  count_r;

    logic [ADDR_W-1:0] pc_plus1_s;
    logic [ADDR_W-1:0] reg_target_s;
    logic [ADDR_W-1:0] ret_target_s;
    logic [ADDR_W-1:0] next_pc_s;
    logic              next_redirect_s;
    logic              next_overflow_s;
    logic [PTR_W-1:0]  next_top_s;
    logic [CNT_W-1:0]  next_count_s;
    logic              wr_en_s;
    logic [PTR_W-1:0]  wr_idx_s;
    logic              ras_has_s;
    logic              ras_full_s;

    assign pc_plus1_s   = pc_r + ADDR_W'(1);
    assign reg_target_s = reg_val[ADDR_W-1:0];
    assign ras_has_s    = (count_r != CNT_W'(0));
    assign ras_full_s   = (count_r == CNT_W'(RAS_DEPTH));
    // An empty stack falls back to the register value so a bare jr-style return still works.
    assign ret_target_s = ras_has_s ? ras_mem_r[top_r] : reg_target_s;

    // Next-PC priority selection.
    always_comb begin
        next_pc_s       = pc_plus1_s;
        next_redirect_s = 1'b0;
        if (jr_en) begin
            next_pc_s       = reg_target_s;
            next_redirect_s = 1'b1;
        end else if (ret_en) begin
            next_pc_s       = ret_target_s;
            next_redirect_s = 1'b1;
        end else if (jump_en) begin
            next_pc_s       = jump_target;
            next_redirect_s = 1'b1;
        end else if (br_en && br_taken) begin
            next_pc_s       = pc_plus1_s + br_offset;
            next_redirect_s = 1'b1;
        end else begin
            next_pc_s       = pc_plus1_s;
            next_redirect_s = 1'b0;
        end
    end

    // Return-address stack pointer, count and write-port control.
    always_comb begin
        next_top_s      = top_r;
        next_count_s    = count_r;
        next_overflow_s = 1'b0;
        wr_en_s         = 1'b0;
        wr_idx_s        = top_r + PTR_W'(1);
        if (link_en && ret_en && ras_has_s) begin
            // Simultaneous call/return swaps the top entry in place.
            wr_en_s  = 1'b1;
            wr_idx_s = top_r;
        end else if (link_en) begin
            // Writing at top+1 when full lands on the oldest entry.
            wr_en_s    = 1'b1;
            next_top_s = top_r + PTR_W'(1);
            if (ras_full_s) begin
                next_overflow_s = 1'b1;
            end else begin
                next_count_s = count_r + CNT_W'(1);
            end
        end else if (ret_en && ras_has_s) begin
            next_top_s   = top_r - PTR_W'(1);
            next_count_s = count_r - CNT_W'(1);
        end else begin
            next_top_s   = top_r;
            next_count_s = count_r;
        end
    end

    // PC, stack pointers and status flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r       <= RESET_PC;
            redirect_r <= 1'b0;
            overflow_r <= 1'b0;
            top_r      <= {PTR_W{1'b0}};
            count_r    <= {CNT_W{1'b0}};
        end else if (stall) begin
            redirect_r <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            pc_r       <= next_pc_s;
            redirect_r <= next_redirect_s;
            overflow_r <= next_overflow_s;
            top_r      <= next_top_s;
            count_r    <= next_count_s;
        end
    end

    // Stack entry storage; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (!rst && !stall && wr_en_s) begin
            ras_mem_r[wr_idx_s] <= pc_plus1_s;
        end
    end

    assign pc           = pc_r;
    assign pc_plus1     = pc_plus1_s;
    assign redirect     = redirect_r;
    assign ras_overflow = overflow_r;
    assign ras_empty    = !ras_has_s;
    assign ras_full     = ras_full_s;

endmodule

// File: tb/tb_pc_next_unit.sv
// Self-checking bench for pc_next_unit: directed scenarios then random traffic against a queue-based model.
module tb_pc_next_unit;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;
    localparam int MASK   = 32'h1FFF;

    logic              clk = 1'b0;
    logic              rst;
    logic              stall;
    logic              jump_en;
    logic [ADDR_W-1:0] jump_target;
    logic              jr_en;
    logic [DATA_W-1:0] reg_val;
    logic              br_en;
    logic              br_taken;
    logic [ADDR_W-1:0] br_offset;
    logic              link_en;
    logic              ret_en;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc_plus1;
    logic              redirect;
    logic              ras_empty;
    logic              ras_full;
    logic              ras_overflow;

    int checks   = 0;
    int failures = 0;

    // Reference model state: PC as an integer, RAS as a queue (newest at the back).
    int m_pc       = 0;
    int m_redirect = 0;
    int m_ovf      = 0;
    int ras_q[$];

    pc_next_unit #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAS_DEPTH(DEPTH), .RESET_PC(13'h0000)
    ) dut (
        .clk(clk), .rst(rst), .stall(stall),
        .jump_en(jump_en), .jump_target(jump_target),
        .jr_en(jr_en), .reg_val(reg_val),
        .br_en(br_en), .br_taken(br_taken), .br_offset(br_offset),
        .link_en(link_en), .ret_en(ret_en),
        .pc(pc), .pc_plus1(pc_plus1), .redirect(redirect),
        .ras_empty(ras_empty), .ras_full(ras_full), .ras_overflow(ras_overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst = 1'b0; stall = 1'b0; jump_en = 1'b0; jump_target = 13'h0000;
        jr_en = 1'b0; reg_val = 16'h0000; br_en = 1'b0; br_taken = 1'b0;
        br_offset = 13'h0000; link_en = 1'b0; ret_en = 1'b0;
    endtask

    // Apply the model for one edge, clock the DUT, then compare every output.
    task automatic tick();
        int ppl;
        int tgt_ret;
        int rv;
        ppl = (m_pc + 1) & MASK;
        rv  = int'(reg_val) & MASK;
        if (rst) begin
            m_pc = 0; m_redirect = 0; m_ovf = 0; ras_q.delete();
        end else if (stall) begin
            m_redirect = 0; m_ovf = 0;
        end else begin
            tgt_ret = (ras_q.size() > 0) ? ras_q[ras_q.size()-1] : rv;
            m_redirect = 1;
            if (jr_en)                m_pc = rv;
            else if (ret_en)          m_pc = tgt_ret;
            else if (jump_en)         m_pc = int'(jump_target);
            else if (br_en && br_taken) m_pc = (ppl + int'(br_offset)) & MASK;
            else begin m_pc = ppl; m_redirect = 0; end
            m_ovf = 0;
            if (link_en && ret_en && ras_q.size() > 0) begin
                ras_q[ras_q.size()-1] = ppl;
            end else if (link_en) begin
                if (ras_q.size() == DEPTH) begin
                    void'(ras_q.pop_front());
                    m_ovf = 1;
                end
                ras_q.push_back(ppl);
            end else if (ret_en && ras_q.size() > 0) begin
                void'(ras_q.pop_back());
            end
        end
        @(posedge clk);
        #1;
        chk("pc", 32'(pc), 32'(m_pc));
        chk("pc_plus1", 32'(pc_plus1), 32'((m_pc + 1) & MASK));
        chk("redirect", 32'(redirect), 32'(m_redirect));
        chk("ras_overflow", 32'(ras_overflow), 32'(m_ovf));
        chk("ras_empty", 32'(ras_empty), 32'(ras_q.size() == 0));
        chk("ras_full", 32'(ras_full), 32'(ras_q.size() == DEPTH));
    endtask

    task automatic jump_to(input logic [ADDR_W-1:0] a);
        idle(); jump_en = 1'b1; jump_target = a; tick(); idle();
    endtask

    initial begin
        idle();
        rst = 1'b1;
        stall = 1'b1; jump_en = 1'b1; jump_target = 13'h0555;
        tick(); tick();
        chk("reset_pc", 32'(pc), 32'h0);
        chk("reset_empty", 32'(ras_empty), 32'h1);
        idle();

        // Free run from reset.
        for (int i = 1; i <= 5; i++) begin
            tick();
            chk("free_run", 32'(pc), 32'(i));
        end

        // Address wrap at the top of the space.
        jump_to(13'h1FFE);
        tick();
        tick();
        chk("wrap", 32'(pc), 32'h0000);

        // Taken and not-taken backward branch.
        jump_to(13'h0010);
        br_en = 1'b1; br_taken = 1'b1; br_offset = 13'h1FFC; tick();
        chk("br_taken", 32'(pc), 32'h000D);
        idle(); jump_to(13'h0010);
        br_en = 1'b1; br_taken = 1'b0; br_offset = 13'h1FFC; tick();
        chk("br_not_taken", 32'(pc), 32'h0011);
        chk("br_not_taken_redirect", 32'(redirect), 32'h0);

        // jr wins over jump and branch; upper register bits dropped.
        idle();
        jr_en = 1'b1; jump_en = 1'b1; jump_target = 13'h0123;
        br_en = 1'b1; br_taken = 1'b1; br_offset = 13'h0004; reg_val = 16'hABCD;
        tick();
        chk("jr_priority", 32'(pc), 32'h0BCD);

        // Five calls then five returns.
        jump_to(13'h0020);
        for (int i = 0; i < 5; i++) begin
            idle(); link_en = 1'b1; jump_en = 1'b1; jump_target = 13'(32'h40 + 32'h20 * i);
            tick();
            if (i == 3) chk("ras_full_after_4", 32'(ras_full), 32'h1);
            if (i == 4) chk("ras_overflow_5th", 32'(ras_overflow), 32'h1);
        end
        idle(); ret_en = 1'b1; reg_val = 16'h0777;
        tick(); chk("ret1", 32'(pc), 32'h00A1);
        tick(); chk("ret2", 32'(pc), 32'h0081);
        tick(); chk("ret3", 32'(pc), 32'h0061);
        tick(); chk("ret4", 32'(pc), 32'h0041);
        tick(); chk("ret_fallback", 32'(pc), 32'h0777);
        chk("ret_fallback_empty", 32'(ras_empty), 32'h1);

        // Stall holds for three cycles, then the jump is taken.
        jump_to(13'h0300);
        stall = 1'b1; jump_en = 1'b1; jump_target = 13'h0456;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", 32'(pc), 32'h0300);
        end
        stall = 1'b0;
        tick();
        chk("stall_release", 32'(pc), 32'h0456);

        // Simultaneous call and return swaps the top entry.
        jump_to(13'h00FF);
        link_en = 1'b1; jump_en = 1'b1; jump_target = 13'h0200; tick();
        idle(); link_en = 1'b1; ret_en = 1'b1; tick();
        chk("link_ret_pc", 32'(pc), 32'h0100);
        chk("link_ret_count", 32'(ras_empty), 32'h0);
        idle(); ret_en = 1'b1; tick();
        chk("link_ret_newtop", 32'(pc), 32'h0201);
        chk("link_ret_empty", 32'(ras_empty), 32'h1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            rst         = 1'($urandom_range(0, 99) == 0);
            stall       = 1'($urandom_range(0, 7) == 0);
            jump_en     = 1'($urandom_range(0, 5) == 0);
            jump_target = 13'($urandom);
            jr_en       = 1'($urandom_range(0, 9) == 0);
            reg_val     = 16'($urandom);
            br_en       = 1'($urandom_range(0, 3) == 0);
            br_taken    = 1'($urandom_range(0, 1));
            br_offset   = 13'($urandom);
            link_en     = 1'($urandom_range(0, 3) == 0);
            ret_en      = 1'($urandom_range(0, 4) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
